issue_scoreboard: RTL and testbench

Parametrised dual/multi-issue hazard scoreboard for the SPU pipes. Tracks every in-flight destination write per issue lane in a latency-indexed slot array, and decides per cycle which lanes of the current bundle may issue. Covers RAW, WAW, write-port collisions, intra-bundle dependencies and branch flush of younger in-flight writes. Sits between decode and the even/odd pipes and replaces the exported per-unit delay address/write vectors with a single stall decision.

---
 rtl/spu_pkg.sv | 17 +
 rtl/sb_lane.sv | 28 ++
 rtl/issue_scoreboard.sv | 70 +++++++
 tb/tb_issue_scoreboard.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: shared SPU register width, unit latencies and the scoreboard slot type.
package spu_pkg;
  localparam int SPU_REG_AW = 7;
  localparam int SPU_MAX_LAT = 7;
  localparam int AGE_W = $clog2(SPU_MAX_LAT + 1);
  localparam int LAT_FP1 = 7;
  localparam int LAT_LS1 = 6;
  localparam int LAT_FX2 = 4;
  localparam int LAT_B1 = 4;
  localparam int LAT_P1 = 4;
  localparam int LAT_FX1 = 2;
  typedef struct packed {
    logic valid;
    logic [SPU_REG_AW-1:0] rt;
    logic [AGE_W-1:0] age;
  } slot_t;
endpackage

// File: rtl/sb_lane.sv
// sb_lane: one issue lane's latency-indexed shift register of in-flight destination writes.
module sb_lane import spu_pkg::*; #(
  parameter int MAX_LAT = SPU_MAX_LAT,
  parameter int KILL_WIN = 2,
  parameter int LW = $clog2(MAX_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic ins,
  input  logic [SPU_REG_AW-1:0] ins_rt,
  input  logic [LW-1:0] ins_lat,
  output slot_t slots [MAX_LAT]
);
  slot_t nxt [MAX_LAT];
  always_comb begin
    for (int s = 0; s < MAX_LAT; s++) nxt[s] = '0;
    for (int s = 0; s < MAX_LAT - 1; s++)
      if (!(flush && slots[s+1].age < AGE_W'(KILL_WIN))) begin
        nxt[s] = slots[s+1];
        nxt[s].age = slots[s+1].age == AGE_W'(MAX_LAT) ? slots[s+1].age : slots[s+1].age + 1'b1;
      end
    for (int s = 0; s < MAX_LAT; s++)
      if (ins && ins_lat == LW'(s + 1)) nxt[s] = '{valid: 1'b1, rt: ins_rt, age: AGE_W'(1)};
  end
  always_ff @(posedge clk)
    for (int s = 0; s < MAX_LAT; s++) slots[s] <= reset ? '0 : nxt[s];
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: tracks in-flight writes per lane and decides in-order issue of the current bundle.
module issue_scoreboard import spu_pkg::*; #(
  parameter int LANES = 2,
  parameter int MAX_LAT = SPU_MAX_LAT,
  parameter int REG_AW = SPU_REG_AW,
  parameter int NUM_SRC = 3,
  parameter int KILL_WIN = 2,
  localparam int LW = $clog2(MAX_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic [LANES-1:0] issue_valid,
  input  logic [LANES-1:0] issue_wr,
  input  logic [LANES-1:0][REG_AW-1:0] issue_rt,
  input  logic [LANES-1:0][LW-1:0] issue_lat,
  input  logic [LANES-1:0][NUM_SRC-1:0] src_used,
  input  logic [LANES-1:0][NUM_SRC-1:0][REG_AW-1:0] src_addr,
  input  logic flush,
  output logic [LANES-1:0] issue_ok,
  output logic stall,
  output logic busy,
  output logic lat_err
);
  slot_t slots [LANES][MAX_LAT];
  logic chain, ok;
  logic [LANES-1:0] bad_lat;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sb_lane #(.MAX_LAT(MAX_LAT), .KILL_WIN(KILL_WIN)) u_lane (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .ins(issue_ok[g] && issue_wr[g]),
      .ins_rt(issue_rt[g]),
      .ins_lat(issue_lat[g]),
      .slots(slots[g])
    );
  end
  // Slot 0 is on the forward path, so only slots 1.. raise RAW stalls.
  always_comb begin
    chain = !reset && !flush;
    ok = 1'b0;
    issue_ok = '0;
    bad_lat = '0;
    busy = 1'b0;
    for (int l = 0; l < LANES; l++)
      for (int t = 0; t < MAX_LAT; t++) busy = busy | slots[l][t].valid;
    busy = busy && !reset;
    for (int k = 0; k < LANES; k++) begin
      bad_lat[k] = issue_wr[k] && (issue_lat[k] == '0 || {1'b0, issue_lat[k]} > (LW+1)'(MAX_LAT));
      ok = chain && issue_valid[k] && !bad_lat[k];
      for (int l = 0; l < LANES; l++)
        for (int t = 1; t < MAX_LAT; t++) begin
          for (int s = 0; s < NUM_SRC; s++)
            if (src_used[k][s] && slots[l][t].valid && slots[l][t].rt == src_addr[k][s]) ok = 1'b0;
          if (issue_wr[k] && slots[l][t].valid && LW'(t) >= issue_lat[k] && slots[l][t].rt == issue_rt[k]) ok = 1'b0;
          if (issue_wr[k] && l == k && slots[l][t].valid && LW'(t) == issue_lat[k]) ok = 1'b0;
        end
      for (int j = 0; j < k; j++)
        if (issue_wr[j]) begin
          for (int s = 0; s < NUM_SRC; s++)
            if (src_used[k][s] && src_addr[k][s] == issue_rt[j]) ok = 1'b0;
          if (issue_wr[k] && issue_rt[k] == issue_rt[j] && issue_lat[k] <= issue_lat[j]) ok = 1'b0;
        end
      issue_ok[k] = ok;
      chain = ok;
    end
  end
  assign stall = !reset && |(issue_valid & ~issue_ok);
  always_ff @(posedge clk) lat_err <= !reset && |(issue_valid & bad_lat);
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed bundles with queued expectations checked by a negedge monitor.
module tb_issue_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] issue_valid, issue_wr, issue_ok;
  logic [1:0][6:0] issue_rt;
  logic [1:0][2:0] issue_lat;
  logic [1:0][2:0] src_used;
  logic [1:0][2:0][6:0] src_addr;
  logic flush, stall, busy, lat_err;
  typedef struct {
    string tag;
    logic [1:0] ok;
    logic stall;
    logic busy;
    logic err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int pass_n = 0;
  int total_n = 0;
  always #5 clk = ~clk;
  issue_scoreboard dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_wr(issue_wr),
    .issue_rt(issue_rt),
    .issue_lat(issue_lat),
    .src_used(src_used),
    .src_addr(src_addr),
    .flush(flush),
    .issue_ok(issue_ok),
    .stall(stall),
    .busy(busy),
    .lat_err(lat_err)
  );
  task automatic chk(string tag, string what, logic [1:0] got, logic [1:0] want);
    total_n++;
    if (got === want) pass_n++;
    else $display("FAIL %s.%s got %b want %b", tag, what, got, want);
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, "issue_ok", issue_ok, e.ok);
      chk(e.tag, "stall", {1'b0, stall}, {1'b0, e.stall});
      chk(e.tag, "busy", {1'b0, busy}, {1'b0, e.busy});
      chk(e.tag, "lat_err", {1'b0, lat_err}, {1'b0, e.err});
    end
  task automatic idle();
    issue_valid = '0;
    issue_wr = '0;
    issue_rt = '0;
    issue_lat = '0;
    src_used = '0;
    src_addr = '0;
    flush = 1'b0;
  endtask
  task automatic wr(int l, logic [6:0] rt, logic [2:0] lat);
    issue_valid[l] = 1'b1;
    issue_wr[l] = 1'b1;
    issue_rt[l] = rt;
    issue_lat[l] = lat;
  endtask
  task automatic rd(int l, logic [6:0] r);
    issue_valid[l] = 1'b1;
    src_used[l][0] = 1'b1;
    src_addr[l][0] = r;
  endtask
  task automatic cyc(string tag, logic [1:0] ok, logic st, logic bu, logic er);
    q.push_back('{tag, ok, st, bu, er});
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    rd(0, 7'd0);
    cyc("rst", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    wr(0, 7'd5, 3'd7);
    cyc("a_wr", 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rd(0, 7'd5);
      cyc("a_raw", 2'b00, 1'b1, 1'b1, 1'b0);
    end
    rd(0, 7'd5);
    cyc("a_fwd", 2'b01, 1'b0, 1'b1, 1'b0);
    cyc("a_idle", 2'b00, 1'b0, 1'b0, 1'b0);
    wr(0, 7'd3, 3'd2);
    rd(1, 7'd3);
    cyc("b_dep", 2'b01, 1'b1, 1'b0, 1'b0);
    rd(0, 7'd3);
    rd(1, 7'd20);
    cyc("b_raw", 2'b00, 1'b1, 1'b1, 1'b0);
    rd(0, 7'd3);
    cyc("b_fwd", 2'b01, 1'b0, 1'b1, 1'b0);
    wr(0, 7'd10, 3'd2);
    wr(1, 7'd10, 3'd2);
    cyc("b_waw", 2'b01, 1'b1, 1'b0, 1'b0);
    wr(0, 7'd12, 3'd2);
    wr(1, 7'd12, 3'd3);
    cyc("b_waw_ok", 2'b11, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc("b_drain", 2'b00, 1'b0, 1'b1, 1'b0);
    wr(0, 7'd9, 3'd6);
    cyc("c_wr", 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wr(0, 7'd9, 3'd2);
      cyc("c_waw", 2'b00, 1'b1, 1'b1, 1'b0);
    end
    wr(0, 7'd9, 3'd2);
    cyc("c_ok", 2'b01, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc("c_drain", 2'b00, 1'b0, 1'b1, 1'b0);
    wr(0, 7'd1, 3'd4);
    cyc("d_wr", 2'b01, 1'b0, 1'b0, 1'b0);
    wr(0, 7'd2, 3'd3);
    cyc("d_port", 2'b00, 1'b1, 1'b1, 1'b0);
    wr(0, 7'd2, 3'd3);
    cyc("d_ok", 2'b01, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc("d_drain", 2'b00, 1'b0, 1'b1, 1'b0);
    wr(0, 7'd1, 3'd7);
    cyc("e_wr1", 2'b01, 1'b0, 1'b0, 1'b0);
    wr(0, 7'd2, 3'd7);
    cyc("e_wr2", 2'b01, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    rd(0, 7'd7);
    cyc("e_flush", 2'b00, 1'b1, 1'b1, 1'b0);
    rd(0, 7'd2);
    rd(1, 7'd1);
    cyc("e_killed", 2'b01, 1'b1, 1'b1, 1'b0);
    rd(0, 7'd1);
    cyc("e_survive", 2'b00, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc("e_drain", 2'b00, 1'b0, 1'b1, 1'b0);
    wr(0, 7'd4, 3'd0);
    cyc("f_lat0", 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("f_err", 2'b00, 1'b0, 1'b0, 1'b1);
    rd(0, 7'd4);
    cyc("f_nowr", 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("f_idle", 2'b00, 1'b0, 1'b0, 1'b0);
    wr(0, 7'd5, 3'd7);
    cyc("g_wr", 2'b01, 1'b0, 1'b0, 1'b0);
    rd(0, 7'd5);
    cyc("g_raw", 2'b00, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    rd(0, 7'd5);
    flush = 1'b1;
    cyc("g_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    rd(0, 7'd5);
    cyc("g_after", 2'b01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("end", "drained", {1'b0, q.size() == 0}, 2'b01);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
